move_entry_ctrl: RTL
====================

Name: move_entry_ctrl

Overview:
Front-end for the tic_tac_toe game core: converts three raw push-buttons (left, right, select) into a cursor over the 9-cell board and full-board move vectors plus a one-cycle OK pulse. Sits directly upstream of the game core and drives its A_move, B_move and OK_btn inputs. Reads back the core's committed board (A_state, B_state) and whose turn it is. Rejects selection of occupied cells locally.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a raw button level must hold before it is accepted.
HOLD_CYCLES, 2, cycles the staged move is held stable after the OK pulse.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
btn_left  input  1  raw button, move cursor down (index-1)
btn_right  input  1  raw button, move cursor up (index+1)
btn_sel  input  1  raw button, place mark at cursor
turn  input  2  current player from core: 2'b01 = A, 2'b10 = B, other = no play
A_state  input  9  committed A cells from core
B_state  input  9  committed B cells from core
A_move  output  9  full-board A vector presented to core
B_move  output  9  full-board B vector presented to core
OK_btn  output  1  one-cycle commit pulse to core
cursor  output  4  cursor cell index 0..8
reject  output  1  one-cycle pulse: select on occupied cell
busy  output  1  high in COMMIT and HOLD

Behaviour:
- Reset (sync, active-high): cursor=4, FSM=IDLE, OK_btn=0, reject=0, busy=0, staged regs=0, debouncers: stable level=0, counters=0. A_move/B_move = A_state/B_state (pass-through) from the first cycle after reset.
- Debounce, per button: if raw != stable level, count up; when count reaches DEBOUNCE_CYCLES-1 while raw still differs, stable level flips on next edge and count clears; any cycle raw == stable clears count. Press pulse = stable rising edge, one cycle. Release generates nothing. Holding a button gives exactly one pulse.
- Latency: raw press held steady -> press pulse DEBOUNCE_CYCLES+1 cycles after the raw rise (+1 edge detect register).
- Cursor (IDLE only): left pulse: cursor==0 -> 8 else cursor-1. right pulse: cursor==8 -> 0 else cursor+1. Left and right pulse in the same cycle: cursor unchanged. Cursor never leaves 0..8.
- FSM states: IDLE, COMMIT, HOLD.
  IDLE: A_move=A_state, B_move=B_state, busy=0. On sel pulse:
    turn not 01/10 -> ignored, no reject.
    cell (A_state|B_state)[cursor]==1 -> reject=1 for one cycle, stay IDLE.
    else latch staged_A = A_state | (turn==01 ? onehot(cursor) : 0), staged_B = B_state | (turn==10 ? onehot(cursor) : 0) -> COMMIT.
    Sel and left/right in the same cycle: select uses the pre-move cursor; cursor update is suppressed.
  COMMIT (1 cycle): OK_btn=1, A_move/B_move=staged, busy=1 -> HOLD.
  HOLD: OK_btn=0, outputs=staged, busy=1, counter runs HOLD_CYCLES cycles -> IDLE.
- All button pulses during COMMIT/HOLD are discarded (not queued); debouncers keep running.
- Staged vectors always differ from the committed board in exactly one bit (placement is never a removal).
- Reset asserted in COMMIT or HOLD: abort. The next cycle is IDLE with OK_btn=0 and pass-through outputs. A staged move is not re-issued.
- OK_btn, reject, busy are registered; there is no combinational path from inputs to them.

Test Plan:
1. Reset, then btn_right high for 10 cycles -> exactly one press; cursor 4->5. The press pulse appears 5 cycles after the raw rise (DEBOUNCE_CYCLES=4).
2. Glitch: btn_left high 3 cycles then low -> no pulse; cursor stays 4.
3. cursor=8, right press -> cursor=0. cursor=0, left press -> cursor=8.
4. turn=01, board empty, cursor=4, sel press -> OK_btn high exactly 1 cycle with A_move=9'h010, B_move=0. busy high for 3 cycles, then pass-through resumes.
5. A_state=9'h010, turn=10, cursor=4, sel -> reject pulses once, OK_btn stays 0. Move to cursor=5, sel -> OK_btn with B_move=9'h020, A_move=9'h010.
6. turn=2'b00, sel -> no OK_btn, no reject. Separately: reset during HOLD -> next cycle busy=0, A_move/B_move equal A_state/B_state.

Source files
------------

// File: rtl/move_entry_ctrl.sv
// move_entry_ctrl
// Front-end for the tic-tac-toe game core. It debounces three raw push-buttons
// (left, right, select) and keeps a cursor over the 9-cell board. When the
// player selects an empty cell, it hands the core a full-board move vector and
// a one-cycle OK pulse. Selecting an occupied cell raises a one-cycle reject
// pulse instead, and no move is sent.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   btn_left   raw button, cursor index-1 (wraps 0 -> 8)
//   btn_right  raw button, cursor index+1 (wraps 8 -> 0)
//   btn_sel    raw button, place mark at cursor
//   turn       current player from core: 01 = A, 10 = B, other = no play
//   A_state    committed A cells from core
//   B_state    committed B cells from core
//   A_move     full-board A vector to core (pass-through while idle)
//   B_move     full-board B vector to core (pass-through while idle)
//   OK_btn     one-cycle commit pulse to core
//   cursor     cursor cell index 0..8
//   reject     one-cycle pulse: select on an occupied cell
//   busy       high while a move is being committed/held
module move_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic [1:0] turn,
  input  logic [8:0] A_state,
  input  logic [8:0] B_state,
  output logic [8:0] A_move,
  output logic [8:0] B_move,
  output logic       OK_btn,
  output logic [3:0] cursor,
  output logic       reject,
  output logic       busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COMMIT, HOLD} state_t;

  // Bit order for the button vectors: [0] = left, [1] = right, [2] = select.
  logic [2:0]    raw;
  logic [2:0]    stable;
  logic [2:0]    stable_d;
  logic [2:0]    press;
  logic [DW-1:0] db_cnt [3];

  assign raw = {btn_sel, btn_right, btn_left};

  // A raw level must differ from the stable level on DEBOUNCE_CYCLES
  // consecutive edges before the stable level flips. The press pulse is
  // registered from the stable rising edge, which adds one cycle of latency.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable   <= '0;
      stable_d <= '0;
      press    <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
      for (int i = 0; i < 3; i++) begin
        if (raw[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= raw[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  state_t        state;
  logic [8:0]    staged_a;
  logic [8:0]    staged_b;
  logic [HW-1:0] hold_cnt;
  logic [8:0]    cell_mask;
  logic          occupied;
  logic          turn_valid;

  assign cell_mask  = 9'b1 << cursor;
  assign occupied   = |((A_state | B_state) & cell_mask);
  assign turn_valid = (turn == 2'b01) || (turn == 2'b10);

  // Staged vectors are only ever driven outside IDLE. Reset forces IDLE, so
  // an aborted move is never re-presented to the core.
  assign A_move = (state == IDLE) ? A_state : staged_a;
  assign B_move = (state == IDLE) ? B_state : staged_b;

  // OK_btn, reject and busy are set here on the same edge as the state
  // change, so none of them has a combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cursor   <= 4'd4;
      OK_btn   <= 1'b0;
      reject   <= 1'b0;
      busy     <= 1'b0;
      staged_a <= '0;
      staged_b <= '0;
      hold_cnt <= '0;
    end else begin
      OK_btn <= 1'b0;
      reject <= 1'b0;
      unique case (state)
        IDLE: begin
          // A select press wins: it acts on the pre-move cursor and swallows
          // any left/right press that arrives in the same cycle.
          if (press[2]) begin
            if (turn_valid) begin
              if (occupied) begin
                reject <= 1'b1;
              end else begin
                staged_a <= A_state | ((turn == 2'b01) ? cell_mask : 9'b0);
                staged_b <= B_state | ((turn == 2'b10) ? cell_mask : 9'b0);
                OK_btn   <= 1'b1;
                busy     <= 1'b1;
                state    <= COMMIT;
              end
            end
          end else if (press[0] && !press[1]) begin
            cursor <= (cursor == 4'd0) ? 4'd8 : cursor - 4'd1;
          end else if (press[1] && !press[0]) begin
            cursor <= (cursor == 4'd8) ? 4'd0 : cursor + 4'd1;
          end
        end
        COMMIT: begin
          hold_cnt <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
